// File: rtl/spike_pkg.sv
// spike_pkg: shared state encoding and width helper for the spike frame builder
package spike_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, PENDING} sfb_state_t;
  function automatic int shift_w(input int max_mag);
    return $clog2(2 * max_mag + 1);
  endfunction
endpackage

// File: rtl/decoder.sv
// decoder: binary to one-hot, all zeros when the input is out of range
module decoder #(
  parameter int IN_W = 3,
  parameter int OUT_N = 5
) (
  input  logic [IN_W-1:0]  sel_i,
  output logic [0:OUT_N-1] onehot_o
);
  for (genvar i = 0; i < OUT_N; i++) begin : g_bit
    assign onehot_o[i] = sel_i == IN_W'(i);
  end
endmodule

// File: rtl/spike_frame_builder.sv
// spike_frame_builder: samples a spike line over LEN cycles into a frame and
// presents it with a one-hot shift through a valid/ready output slot
module spike_frame_builder
  import spike_pkg::*;
#(
  parameter int LEN = 8,
  parameter int MAX_SHIFT_MAG = 2,
  localparam int SHIFT_W = shift_w(MAX_SHIFT_MAG),
  localparam int OH_N = 2 * MAX_SHIFT_MAG + 1,
  localparam int CNT_W = $clog2(LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               spike_in,
  input  logic [SHIFT_W-1:0] shift_in,
  output logic [0:LEN-1]     frame_out,
  output logic [0:OH_N-1]    shift_onehot_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               start_drop
);
  sfb_state_t state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:LEN-1] buf_q, buf_d, frame_q, frame_d;
  logic [0:OH_N-1] shift_q, shift_d, onehot_q, onehot_d, dec_oh;
  logic valid_q, valid_d, drop_q, drop_d;
  logic slot_free, last, xfer;

  decoder #(.IN_W(SHIFT_W), .OUT_N(OH_N)) u_dec (.sel_i(shift_in), .onehot_o(dec_oh));

  assign slot_free = !valid_q || out_ready;
  assign last = count_q == CNT_W'(LEN - 1);
  assign xfer = slot_free && ((state_q == COLLECT && last) || state_q == PENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? COLLECT : IDLE;
      COLLECT: state_d = !last ? COLLECT : slot_free ? IDLE : PENDING;
      PENDING: state_d = slot_free ? IDLE : PENDING;
      default: state_d = IDLE;
    endcase
  end

  // the final sample joins the buffer in the same cycle it is transferred
  always_comb begin
    buf_d = buf_q;
    count_d = count_q;
    shift_d = shift_q;
    if (state_q == IDLE && start) begin
      buf_d = '0;
      buf_d[0] = spike_in;
      count_d = CNT_W'(1);
      shift_d = dec_oh;
    end else if (state_q == COLLECT) begin
      buf_d[count_q] = spike_in;
      count_d = count_q + 1'b1;
    end
    frame_d = xfer ? buf_d : frame_q;
    onehot_d = xfer ? shift_q : onehot_q;
    valid_d = xfer || (valid_q && !out_ready);
    drop_d = start && state_q != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      buf_q <= '0;
      shift_q <= '0;
      frame_q <= '0;
      onehot_q <= '0;
      valid_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      count_q <= count_d;
      buf_q <= buf_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
      onehot_q <= onehot_d;
      valid_q <= valid_d;
      drop_q <= drop_d;
    end
  end

  assign frame_out = frame_q;
  assign shift_onehot_out = onehot_q;
  assign out_valid = valid_q;
  assign busy = state_q != IDLE;
  assign start_drop = drop_q;
endmodule

// File: tb/tb_spike_frame_builder.sv
// tb_spike_frame_builder: directed vectors and multi-cycle sequences for LEN=8, MAX_SHIFT_MAG=2
module tb_spike_frame_builder;
  logic clk = 1'b0;
  logic rst_n, start, spike_in, out_ready;
  logic [2:0] shift_in;
  logic [0:7] frame_out;
  logic [0:4] shift_onehot_out;
  logic out_valid, busy, start_drop;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [0:7] spikes;
    logic [2:0] sh;
    logic [0:7] ef;
    logic [0:4] eo;
  } vec_t;
  vec_t v[7];

  spike_frame_builder #(.LEN(8), .MAX_SHIFT_MAG(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spike_in(spike_in), .shift_in(shift_in),
    .frame_out(frame_out), .shift_onehot_out(shift_onehot_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .start_drop(start_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " valid"}, 32'(out_valid), 32'd0);
    check({name, " frame"}, 32'(frame_out), 32'd0);
    check({name, " onehot"}, 32'(shift_onehot_out), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " drop"}, 32'(start_drop), 32'd0);
  endtask

  // drives one full 8-cycle window; shift_in is scrambled after t=0 to prove capture
  task automatic run_frame(input logic [0:7] spikes, input logic [2:0] sh);
    for (int t = 0; t < 8; t++) begin
      start = (t == 0);
      spike_in = spikes[t];
      shift_in = (t == 0) ? sh : ~sh;
      step();
    end
    start = 1'b0;
    spike_in = 1'b0;
  endtask

  initial begin
    logic [0:7] a, b, c;
    v[0] = '{8'b0100_0000, 3'd3, 8'b0100_0000, 5'b00010};
    v[1] = '{8'b1100_0110, 3'd0, 8'b1100_0110, 5'b10000};
    v[2] = '{8'b0000_0001, 3'd4, 8'b0000_0001, 5'b00001};
    v[3] = '{8'b1000_0000, 3'd2, 8'b1000_0000, 5'b00100};
    v[4] = '{8'b1111_1111, 3'd1, 8'b1111_1111, 5'b01000};
    v[5] = '{8'b1010_0101, 3'd6, 8'b1010_0101, 5'b00000};
    v[6] = '{8'b0011_1100, 3'd7, 8'b0011_1100, 5'b00000};
    rst_n = 1'b0; start = 1'b0; spike_in = 1'b0; shift_in = '0; out_ready = 1'b1;
    #1;
    check_idle_outputs("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      run_frame(v[i].spikes, v[i].sh);
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d frame", i), 32'(frame_out), 32'(v[i].ef));
      check($sformatf("vec%0d onehot", i), 32'(shift_onehot_out), 32'(v[i].eo));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
      step();
      check($sformatf("vec%0d valid_drop", i), 32'(out_valid), 32'd0);
    end

    // back-to-back with a dropped start at cycle 4
    a = 8'b1001_1001; b = 8'b0110_0000; c = 8'b0000_1011;
    out_ready = 1'b1;
    shift_in = 3'd2;
    for (int k = 0; k <= 25; k++) begin
      if (k == 1) check("b2b busy1", 32'(busy), 32'd1);
      if (k == 4) check("b2b drop4", 32'(start_drop), 32'd0);
      if (k == 5) check("b2b drop5", 32'(start_drop), 32'd1);
      if (k == 6) check("b2b drop6", 32'(start_drop), 32'd0);
      if (k == 7) check("b2b valid7", 32'(out_valid), 32'd0);
      if (k == 8) begin
        check("b2b valid8", 32'(out_valid), 32'd1);
        check("b2b frame8", 32'(frame_out), 32'(a));
        check("b2b onehot8", 32'(shift_onehot_out), 32'b00100);
        check("b2b busy8", 32'(busy), 32'd0);
      end
      if (k == 9) check("b2b valid9", 32'(out_valid), 32'd0);
      if (k == 16) begin
        check("b2b valid16", 32'(out_valid), 32'd1);
        check("b2b frame16", 32'(frame_out), 32'(b));
      end
      if (k == 24) begin
        check("b2b valid24", 32'(out_valid), 32'd1);
        check("b2b frame24", 32'(frame_out), 32'(c));
      end
      if (k == 25) check("b2b valid25", 32'(out_valid), 32'd0);
      start = (k == 0 || k == 4 || k == 8 || k == 16);
      spike_in = k < 8 ? a[k % 8] : k < 16 ? b[k % 8] : k < 24 ? c[k % 8] : 1'b0;
      step();
    end
    start = 1'b0; spike_in = 1'b0;
    step();

    // backpressure: second frame parks in PENDING until the slot is released
    a = 8'b0011_0000; b = 8'b1000_0011;
    out_ready = 1'b0;
    for (int k = 0; k <= 22; k++) begin
      if (k == 8) begin
        check("bp valid8", 32'(out_valid), 32'd1);
        check("bp frame8", 32'(frame_out), 32'(a));
      end
      if (k == 16 || k == 17 || k == 19) check($sformatf("bp busy%0d", k), 32'(busy), 32'd1);
      if (k == 16 || k == 20) begin
        check($sformatf("bp hold_frame%0d", k), 32'(frame_out), 32'(a));
        check($sformatf("bp hold_onehot%0d", k), 32'(shift_onehot_out), 32'b01000);
        check($sformatf("bp hold_valid%0d", k), 32'(out_valid), 32'd1);
      end
      if (k == 21) begin
        check("bp valid21", 32'(out_valid), 32'd1);
        check("bp frame21", 32'(frame_out), 32'(b));
        check("bp onehot21", 32'(shift_onehot_out), 32'b00010);
        check("bp busy21", 32'(busy), 32'd0);
      end
      if (k == 22) check("bp valid22", 32'(out_valid), 32'd0);
      start = (k == 0 || k == 8);
      shift_in = k == 0 ? 3'd1 : k == 8 ? 3'd3 : 3'd0;
      spike_in = k < 8 ? a[k % 8] : k < 16 ? b[k % 8] : 1'b1;
      out_ready = k >= 20;
      step();
    end
    start = 1'b0; spike_in = 1'b0;

    // reset mid-collect while an older frame is still held in the slot
    out_ready = 1'b0;
    run_frame(8'b1010_1010, 3'd0);
    check("rst held_valid", 32'(out_valid), 32'd1);
    for (int t = 0; t < 4; t++) begin
      start = (t == 0);
      spike_in = 1'b1;
      shift_in = 3'd4;
      step();
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check_idle_outputs("postrst");
    run_frame(8'b0000_0100, 3'd2);
    check("postrst frame", 32'(frame_out), 32'b0000_0100);
    check("postrst onehot", 32'(shift_onehot_out), 32'b00100);
    check("postrst valid", 32'(out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spike_frame_builder.md
# spike_frame_builder

Serial-to-parallel front end for the spike-time shifter. Samples a 1-bit spike line once per clock over a LEN-cycle window, assembles the LEN-bit spike frame (index 0 = t=0), and captures a binary shift magnitude converted to one-hot. It presents frame and one-hot shift to the downstream `combShifter` through a valid/ready register slice. Sits directly upstream of `combShifter` configured with `SHIFT_AS_ONE_HOT=1`.

## Interface
- `LEN`, default 8: frame length in timesteps; must be ≥2.
- `MAX_SHIFT_MAG`, default 2: shift range ±MAX_SHIFT_MAG; one-hot width 2*MAX_SHIFT_MAG+1.
- `SHIFT_W`, default $clog2(2*MAX_SHIFT_MAG+1): binary shift width; derived, not overridden.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a frame; samples `spike_in` as t=0 in the same cycle.
- `spike_in` in 1: spike present at the current timestep.
- `shift_in` in SHIFT_W: binary shift magnitude (0 → −MAX, MAX → 0, 2*MAX → +MAX), captured on accepted `start`.
- `frame_out` out [0:LEN-1]: assembled spike frame; bit t set if a spike was sampled at t.
- `shift_onehot_out` out [0:2*MAX_SHIFT_MAG]: one-hot shift matching `frame_out`.
- `out_valid` out 1: output slot holds a frame.
- `out_ready` in 1: downstream accepts the frame when high together with `out_valid`.
- `busy` out 1: state is not IDLE.
- `start_drop` out 1: one-cycle pulse when a `start` is ignored.

## Operation
- States: IDLE, COLLECT, PENDING.
- IDLE: on `start`, clear the collect buffer, write `spike_in` to bit 0, set the count to 1, capture `shift_in`, and go to COLLECT.
- COLLECT: each cycle, write `spike_in` to bit `count` and increment `count`.
  - On the sample with `count==LEN-1`: if the output slot is free, or is being consumed this cycle, transfer the buffer and shift to the output slot and go to IDLE.
  - Otherwise go to PENDING.
- PENDING: hold the buffer. When the slot frees (`out_valid & out_ready`, or `out_valid` low), transfer and go to IDLE.
- `spike_in` is ignored in PENDING and in IDLE without `start`.
- `start` in COLLECT or PENDING is ignored and pulses `start_drop` in the next cycle.
- Output slot: `out_valid` sets on transfer and clears on handshake.
  - Transfer and handshake in the same cycle: the new frame replaces the old one and `out_valid` stays high.
  - `frame_out` and `shift_onehot_out` are stable while `out_valid & !out_ready`.
- Shift conversion: `shift_in` > 2*MAX_SHIFT_MAG yields an all-zero one-hot. The frame is still delivered, and downstream outputs all zeros.
- Multiple spikes per window (unions) are preserved bit-for-bit.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `count` 0.
  - Buffers 0.
- Reset mid-COLLECT or mid-PENDING discards the partial frame.
- Latency: with `start` in cycle c, samples t=0..LEN-1 are taken in cycles c..c+LEN-1.
  - `out_valid` is high in cycle c+LEN if the slot is free.
- Throughput: a new `start` is accepted in cycle c+LEN (IDLE), giving one frame per LEN cycles with `out_ready` held high.
- PENDING adds exactly the number of cycles until the slot frees. Transfer occurs on the edge ending the freeing handshake cycle.
- `busy` is high from cycle c+1 until IDLE is re-entered.

## Structure
- Package `spike_pkg`:
  - state enum `sfb_state_t` {IDLE, COLLECT, PENDING};
  - function `shift_w(max)` returning $clog2(2*max+1).
- Sub-module: the existing `decoder` (binary→one-hot, zero when out of range) is instantiated for shift conversion. Its output is registered at capture time, not combinationally at the output.
- `count` width: $clog2(LEN).

## Test plan
- LEN=8, MAX=2: `start` with spike at t=1 only, `shift_in`=3, `out_ready`=1 -> cycle c+8: `frame_out`=0100_0000, `shift_onehot_out`=00010, `out_valid`=1 for one cycle.
- Union frame: spikes at t=0,1,5,6, `shift_in`=0 -> `frame_out`=1100_0110, `shift_onehot_out`=10000.
- Back-to-back: `start` at cycles 0, 8 and 16, `out_ready`=1 -> `out_valid` high at cycles 8, 16 and 24. The `start` at cycle 4 pulses `start_drop` at cycle 5.
- Backpressure: `out_ready`=0, two frames -> the second frame enters PENDING at cycle 16 with `busy`=1 and the first frame held stable. Raise `out_ready` at cycle 20 -> the second frame is presented at cycle 21.
- Out of range: `shift_in`=6 -> `shift_onehot_out`=00000 and the frame is delivered intact.
- Reset: assert `rst_n`=0 at t=4 of a frame -> all outputs 0 immediately. After release, a fresh `start` produces a correct frame with no residue.
